// File: rtl/piso_serializer_if.sv
// Load/serial-output bundle for piso_serializer.
// The master drives the load word and the shift strobe; the slave is the serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 10
) ();
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             enable;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data, enable,
        input  load_ready, out, out_valid, busy, done
    );

    modport slave (
        input  load_valid, load_data, enable,
        output load_ready, out, out_valid, busy, done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: one bit per enable strobe, LSB- or MSB-first.
// Define PARITY_SER_EN to append an even-parity bit after the data bits of each frame.
module piso_serializer #(
    parameter int unsigned WIDTH     = 10,
    parameter bit          MSB_FIRST = 1'b0
) (
    input logic              clk,
    input logic              reset,
    piso_serializer_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
`ifdef PARITY_SER_EN
    localparam logic [1:0] StPar   = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
`ifdef PARITY_SER_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
`ifdef PARITY_SER_EN
        par_d       = par_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.load_valid) begin
                    shreg_d = bus.load_data;
                    cnt_d   = CntW'(WIDTH);
                    out_d   = 1'b0;
                    state_d = StShift;
`ifdef PARITY_SER_EN
                    par_d   = ^bus.load_data;
`endif
                end
            end
            StShift: begin
                if (bus.enable) begin
                    // Shift toward the emitting end; the vacated bit fills with 0.
                    if (MSB_FIRST) begin
                        out_d   = shreg_q[WIDTH-1];
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        out_d   = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end
                    cnt_d       = cnt_q - CntW'(1);
                    out_valid_d = 1'b1;
                    if (cnt_q == CntW'(1)) begin
`ifdef PARITY_SER_EN
                        state_d = StPar;
`else
                        state_d = StIdle;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef PARITY_SER_EN
            StPar: begin
                if (bus.enable) begin
                    out_d       = par_q;
                    out_valid_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef PARITY_SER_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef PARITY_SER_EN
            par_q       <= par_d;
`endif
        end
    end

    assign bus.load_ready = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.out        = out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.done       = done_q;
endmodule
